// File: rtl/fsmc_txn_scheduler_if.sv
// Request/acknowledge bus between the FSMC transaction scheduler and its peripherals.
// The scheduler drives the master side; each peripheral owns one req/ack/rdata slot.
interface fsmc_txn_scheduler_if #(
  parameter int unsigned NUM_MODULES = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16
);
  logic [NUM_MODULES-1:0]            m_req;
  logic                              m_we;
  logic [ADDR_WIDTH-1:0]             m_addr;
  logic [DATA_WIDTH-1:0]             m_wdata;
  logic [NUM_MODULES-1:0]            m_ack;
  logic [NUM_MODULES*DATA_WIDTH-1:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/fsmc_txn_scheduler.sv
// Converts FSMC interface strobes into one req/ack transaction at a time toward the
// selected peripheral, with a per-request timeout and a saturating error counter.
module fsmc_txn_scheduler #(
  parameter int unsigned           NUM_MODULES    = 4,
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           TIMEOUT_CYCLES = 15,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA  = 16'hDEAD
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MODULES-1:0] bus_cs_i,
  input  logic                   bus_addr_en_i,
  input  logic                   bus_rd_en_i,
  input  logic                   bus_wr_en_i,
  input  logic [DATA_WIDTH-1:0]  bus_data_i,
  output logic [DATA_WIDTH-1:0]  bus_rdata_o,
  output logic                   busy_o,
  output logic                   err_pulse_o,
  output logic [7:0]             err_count_o,
  fsmc_txn_scheduler_if.master   m_if
);

  localparam int unsigned SEL_W = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WR_REQ,
    RD_REQ,
    RD_HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MODULES-1:0] m_req_q, m_req_d;
  logic                   m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]  m_wdata_q, m_wdata_d;
  logic [DATA_WIDTH-1:0]  bus_rdata_q, bus_rdata_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [7:0]             err_count_q, err_count_d;
  logic                   cs_any_q;
  logic                   wr_en_q;

  logic                   cs_rise;
  logic                   cs_onehot;
  logic                   wr_rise;
  logic [SEL_W-1:0]       cs_idx;
  logic                   ack_sel;
  logic [DATA_WIDTH-1:0]  rdata_sel;
  logic [CNT_W-1:0]       cnt_inc;
  logic [NUM_MODULES-1:0] req_onehot;
  logic                   err;

  assign cs_rise    = (bus_cs_i != '0) && !cs_any_q;
  assign cs_onehot  = (bus_cs_i != '0) &&
                      ((bus_cs_i & (bus_cs_i - NUM_MODULES'(1))) == '0);
  assign wr_rise    = bus_wr_en_i && !wr_en_q;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign req_onehot = NUM_MODULES'(1) << sel_q;

  // Index of the set chip-select bit; only meaningful when cs is one-hot.
  always_comb begin
    cs_idx = '0;
    for (int unsigned i = 0; i < NUM_MODULES; i++) begin
      if (bus_cs_i[i]) cs_idx = SEL_W'(i);
    end
  end

  // Ack and read data of the latched module; other modules are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_MODULES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ack_sel   = m_if.m_ack[i];
        rdata_sel = m_if.m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    bus_rdata_d = bus_rdata_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    err         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_rise) begin
          if (!cs_onehot) begin
            err = 1'b1;
          end else if (bus_addr_en_i) begin
            m_addr_d = ADDR_WIDTH'(bus_data_i);
            sel_d    = cs_idx;
            state_d  = ARMED;
          end
        end
      end

      ARMED: begin
        // A write strobe beats a simultaneous read rise; the dropped read is an error.
        if (bus_rd_en_i) begin
          m_wdata_d = bus_data_i;
          m_we_d    = 1'b1;
          m_req_d   = req_onehot;
          cnt_d     = '0;
          err       = wr_rise;
          state_d   = WR_REQ;
        end else if (wr_rise) begin
          m_we_d  = 1'b0;
          m_req_d = req_onehot;
          cnt_d   = '0;
          state_d = RD_REQ;
        end else if (bus_cs_i == '0) begin
          state_d = IDLE;
        end
      end

      WR_REQ, RD_REQ: begin
        cnt_d = cnt_inc;
        // Ack is checked first so an ack on the expiry cycle still succeeds.
        if (ack_sel) begin
          m_req_d = '0;
          if (state_q == RD_REQ) begin
            bus_rdata_d = rdata_sel;
            state_d     = RD_HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          m_req_d = '0;
          err     = 1'b1;
          if (state_q == RD_REQ) begin
            bus_rdata_d = DEFAULT_RDATA;
            state_d     = RD_HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      RD_HOLD: begin
        if (!bus_wr_en_i) state_d = IDLE;
      end

      default: begin
        m_req_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    err_pulse_d = err;
    err_count_d = (err && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      m_req_q     <= '0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      bus_rdata_q <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      cs_any_q    <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      bus_rdata_q <= bus_rdata_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      cs_any_q    <= (bus_cs_i != '0);
      wr_en_q     <= bus_wr_en_i;
    end
  end

  assign m_if.m_req   = m_req_q;
  assign m_if.m_we    = m_we_q;
  assign m_if.m_addr  = m_addr_q;
  assign m_if.m_wdata = m_wdata_q;
  assign bus_rdata_o  = bus_rdata_q;
  assign busy_o       = busy_q;
  assign err_pulse_o  = err_pulse_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_fsmc_txn_scheduler.sv
// Bench for fsmc_txn_scheduler: per-cycle vector table, directed corner sequences,
// and random transactions scored against a transaction-level model.
module tb_fsmc_txn_scheduler;

  localparam logic [15:0] DEAD = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  bus_cs;
  logic        ae, rd, wr;
  logic [15:0] data;
  logic [15:0] rdata;
  logic        busy, err_pulse;
  logic [7:0]  err_count;

  int total, bad, pulses;

  fsmc_txn_scheduler_if #(.NUM_MODULES(4), .DATA_WIDTH(16), .ADDR_WIDTH(16)) mif ();

  fsmc_txn_scheduler #(
    .NUM_MODULES(4), .DATA_WIDTH(16), .ADDR_WIDTH(16),
    .TIMEOUT_CYCLES(15), .DEFAULT_RDATA(16'hDEAD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_cs_i      (bus_cs),
    .bus_addr_en_i (ae),
    .bus_rd_en_i   (rd),
    .bus_wr_en_i   (wr),
    .bus_data_i    (data),
    .bus_rdata_o   (rdata),
    .busy_o        (busy),
    .err_pulse_o   (err_pulse),
    .err_count_o   (err_count),
    .m_if          (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cs;
    logic        ae, rd, wr;
    logic [15:0] d;
    logic [3:0]  ack;
    logic [3:0]  req;
    logic        we;
    logic        busy;
    logic [15:0] rdata;
    logic [7:0]  err;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(logic [3:0] cs, logic a, logic r, logic w, logic [15:0] d,
                              logic [3:0] ack, logic [3:0] req, logic we, logic b,
                              logic [15:0] rdv, logic [7:0] e);
    vec_t v;
    v.cs = cs; v.ae = a; v.rd = r; v.wr = w; v.d = d; v.ack = ack;
    v.req = req; v.we = we; v.busy = b; v.rdata = rdv; v.err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus_cs = '0; ae = 0; rd = 0; wr = 0; data = '0;
    mif.m_ack = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    pulses = 0;
  endtask

  function automatic logic [7:0] sat_add(logic [7:0] c, int n);
    int s = int'(c) + n;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  logic [15:0] slot [4];
  logic [7:0]  exp_err;
  logic [15:0] exp_rdata;
  int          exp_pulses;

  // One random transaction; expectations come from the transaction rules, not cycles.
  task automatic rand_txn(input int idx);
    int          kind = int'($urandom_range(0, 9));
    int          mod  = int'($urandom_range(0, 3));
    logic [3:0]  oh   = 4'(1 << mod);
    logic [15:0] addr = 16'($urandom);
    logic [15:0] wd   = 16'($urandom);
    logic [3:0]  bc;
    logic        is_wr;
    int          d, n, exp_n, errs;
    bit          done;
    if (kind == 0) begin
      do bc = 4'($urandom); while ($countones(bc) < 2);
      bus_cs = bc; ae = 1; data = addr; tick(); ae = 0;
      chk($sformatf("rnd%0d_badcs_req", idx), mif.m_req, 4'b0);
      chk($sformatf("rnd%0d_badcs_busy", idx), busy, 0);
      bus_cs = '0; tick();
      exp_err = sat_add(exp_err, 1); exp_pulses++;
    end else if (kind == 1) begin
      bus_cs = oh; ae = 1; data = addr; tick(); ae = 0;
      bus_cs = '0; tick();
      chk($sformatf("rnd%0d_abort_busy", idx), busy, 0);
      chk($sformatf("rnd%0d_abort_req", idx), mif.m_req, 4'b0);
    end else begin
      is_wr = (kind <= 5);
      errs  = (kind == 2) ? 1 : 0;
      for (int s = 0; s < 4; s++) slot[s] = 16'($urandom);
      mif.m_rdata = {slot[3], slot[2], slot[1], slot[0]};
      bus_cs = oh; ae = 1; data = addr; tick(); ae = 0;
      chk($sformatf("rnd%0d_addr", idx), mif.m_addr, addr);
      if (is_wr) begin
        rd = 1; wr = (kind == 2); data = wd; tick(); rd = 0; wr = 0;
      end else begin
        wr = 1; tick();
      end
      d = int'($urandom_range(0, 17));
      n = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        if (mif.m_req != 4'b0) begin
          n++;
          chk($sformatf("rnd%0d_req", idx), mif.m_req, oh);
          chk($sformatf("rnd%0d_we", idx), mif.m_we, is_wr);
          mif.m_ack = (n == d + 1) ? oh : (4'($urandom) & ~oh);
          bus_cs = 4'($urandom_range(1, 15));
          tick();
          mif.m_ack = '0;
        end else begin
          done = 1;
        end
      end
      exp_n = (d + 1 <= 15) ? d + 1 : 15;
      if (d + 1 > 15) errs++;
      chk($sformatf("rnd%0d_req_cycles", idx), n, exp_n);
      if (is_wr) begin
        chk($sformatf("rnd%0d_wdata", idx), mif.m_wdata, wd);
        chk($sformatf("rnd%0d_wr_busy", idx), busy, 0);
      end else begin
        exp_rdata = (d + 1 <= 15) ? slot[mod] : DEAD;
        chk($sformatf("rnd%0d_hold_busy", idx), busy, 1);
        wr = 0; tick();
        chk($sformatf("rnd%0d_rd_busy", idx), busy, 0);
      end
      exp_err = sat_add(exp_err, errs);
      exp_pulses += errs;
      bus_cs = '0; tick();
    end
    chk($sformatf("rnd%0d_rdata", idx), rdata, exp_rdata);
    chk($sformatf("rnd%0d_errcnt", idx), err_count, exp_err);
    chk($sformatf("rnd%0d_pulses", idx), pulses, exp_pulses);
  endtask

  initial begin
    int  n;
    bit  done;
    total = 0; bad = 0; pulses = 0;
    mif.m_rdata = '0;

    do_reset();
    chk("rst_req", mif.m_req, 4'b0);
    chk("rst_we", mif.m_we, 0);
    chk("rst_addr", mif.m_addr, 16'h0);
    chk("rst_wdata", mif.m_wdata, 16'h0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_errcnt", err_count, 8'h0);

    // Write, read, bad select, collision and abort as per-cycle vectors.
    tbl[0]  = mk(4'b0010, 1, 0, 0, 16'h0012, 4'b0000, 4'b0000, 0, 1, 16'h0000, 0);
    tbl[1]  = mk(4'b0010, 0, 1, 0, 16'hA5A5, 4'b0000, 4'b0010, 1, 1, 16'h0000, 0);
    tbl[2]  = mk(4'b0010, 0, 0, 0, 16'h0000, 4'b0000, 4'b0010, 1, 1, 16'h0000, 0);
    tbl[3]  = mk(4'b0010, 0, 0, 0, 16'h0000, 4'b0001, 4'b0010, 1, 1, 16'h0000, 0);
    tbl[4]  = mk(4'b0010, 0, 0, 0, 16'h0000, 4'b0010, 4'b0000, 0, 0, 16'h0000, 0);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 0);
    tbl[6]  = mk(4'b0100, 1, 0, 0, 16'h0003, 4'b0000, 4'b0000, 0, 1, 16'h0000, 0);
    tbl[7]  = mk(4'b0100, 0, 0, 1, 16'h0000, 4'b0000, 4'b0100, 0, 1, 16'h0000, 0);
    tbl[8]  = mk(4'b0100, 0, 0, 1, 16'h0000, 4'b1000, 4'b0100, 0, 1, 16'h0000, 0);
    tbl[9]  = mk(4'b0100, 0, 0, 1, 16'h0000, 4'b0100, 4'b0000, 0, 1, 16'h1234, 0);
    tbl[10] = mk(4'b0000, 0, 0, 1, 16'h0000, 4'b0000, 4'b0000, 0, 1, 16'h1234, 0);
    tbl[11] = mk(4'b0000, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 16'h1234, 0);
    tbl[12] = mk(4'b0110, 1, 0, 0, 16'h0009, 4'b0000, 4'b0000, 0, 0, 16'h1234, 1);
    tbl[13] = mk(4'b0000, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 16'h1234, 1);
    tbl[14] = mk(4'b0001, 1, 0, 0, 16'h0007, 4'b0000, 4'b0000, 0, 1, 16'h1234, 1);
    tbl[15] = mk(4'b0001, 0, 1, 1, 16'hBEEF, 4'b0000, 4'b0001, 1, 1, 16'h1234, 2);
    tbl[16] = mk(4'b0001, 0, 0, 1, 16'h0000, 4'b0001, 4'b0000, 0, 0, 16'h1234, 2);
    tbl[17] = mk(4'b0000, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 16'h1234, 2);
    tbl[18] = mk(4'b1000, 1, 0, 0, 16'h0055, 4'b0000, 4'b0000, 0, 1, 16'h1234, 2);
    tbl[19] = mk(4'b0000, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 16'h1234, 2);
    tbl[20] = mk(4'b0000, 0, 0, 0, 16'h0000, 4'b0000, 4'b0000, 0, 0, 16'h1234, 2);

    mif.m_rdata = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
    for (int i = 0; i < NV; i++) begin
      bus_cs = tbl[i].cs; ae = tbl[i].ae; rd = tbl[i].rd; wr = tbl[i].wr;
      data = tbl[i].d; mif.m_ack = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_req", i), mif.m_req, tbl[i].req);
      if (tbl[i].req != 4'b0) chk($sformatf("tbl%0d_we", i), mif.m_we, tbl[i].we);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rdata);
      chk($sformatf("tbl%0d_errcnt", i), err_count, tbl[i].err);
      if (i == 1) begin
        chk("tbl_addr", mif.m_addr, 16'h0012);
        chk("tbl_wdata", mif.m_wdata, 16'hA5A5);
      end
    end
    mif.m_ack = '0; rd = 0; wr = 0; bus_cs = '0;

    // Read timeout: request held exactly TIMEOUT_CYCLES, default data returned.
    do_reset();
    bus_cs = 4'b0100; ae = 1; data = 16'h0003; tick(); ae = 0;
    wr = 1; n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mif.m_req != 4'b0) n++;
    end
    chk("to_req_cycles", n, 15);
    chk("to_rdata", rdata, DEAD);
    chk("to_pulses", pulses, 1);
    chk("to_errcnt", err_count, 8'd1);
    chk("to_hold_busy", busy, 1);
    wr = 0; bus_cs = '0; tick();
    chk("to_idle_busy", busy, 0);

    // Ack arriving on the last permitted cycle is a success.
    do_reset();
    bus_cs = 4'b1000; ae = 1; data = 16'h0042; tick(); ae = 0;
    rd = 1; data = 16'h5A5A; tick(); rd = 0;
    repeat (14) tick();
    chk("edge_req_hi", mif.m_req, 4'b1000);
    mif.m_ack = 4'b1000; tick(); mif.m_ack = '0;
    chk("edge_req_lo", mif.m_req, 4'b0);
    chk("edge_busy", busy, 0);
    chk("edge_errcnt", err_count, 8'd0);
    chk("edge_pulses", pulses, 0);
    chk("edge_wdata", mif.m_wdata, 16'h5A5A);
    bus_cs = '0; tick();

    // 300 write timeouts saturate the error counter.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      bus_cs = 4'b0001; ae = 1; data = 16'(k); tick(); ae = 0;
      rd = 1; tick(); rd = 0; bus_cs = '0;
      done = 0;
      for (int c = 0; c < 30 && !done; c++) begin
        tick();
        if (!busy) done = 1;
      end
      chk($sformatf("sat%0d_done", k), done, 1);
    end
    chk("sat_errcnt", err_count, 8'hFF);
    chk("sat_pulses", pulses, 300);

    // Reset during an active request drops m_req without waiting for a clock.
    do_reset();
    bus_cs = 4'b0010; ae = 1; data = 16'h0011; tick(); ae = 0;
    wr = 1; tick(); tick(); tick();
    chk("arst_req_before", mif.m_req, 4'b0010);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_req_now", mif.m_req, 4'b0);
    chk("arst_busy_now", busy, 0);
    bus_cs = '0; wr = 0;
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    chk("arst_busy_after", busy, 0);
    chk("arst_req_after", mif.m_req, 4'b0);
    bus_cs = 4'b1000; ae = 1; data = 16'h0077; tick(); ae = 0;
    chk("arst_rearm_busy", busy, 1);
    chk("arst_rearm_addr", mif.m_addr, 16'h0077);
    bus_cs = '0; tick();
    chk("arst_abort_busy", busy, 0);

    // Random transactions against the reference model.
    do_reset();
    exp_err = '0; exp_rdata = '0; exp_pulses = 0;
    for (int t = 0; t < 150; t++) rand_txn(t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
